// File: rtl/apb4_mem_pkg.sv
// Shared types and helpers for the APB4 memory-mapped slave.
// Holds the transfer state encoding, the wait-counter width and the sizing functions.
package apb4_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Wide enough for WAIT_STATES up to 15.
   localparam int WAIT_W = 4;

   function automatic int strb_w(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int idx_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/apb4_mem_array.sv
// Word storage for the APB4 slave: byte-enable write, registered read, clear on reset.
// An out-of-range read loads zero; the caller supplies the range decision via rhit.
module apb4_mem_array
   import apb4_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        we,
   input  logic [idx_w(DEPTH)-1:0]     waddr,
   input  logic [DATA_W-1:0]           wdata,
   input  logic [strb_w(DATA_W)-1:0]   wstrb,
   input  logic                        re,
   input  logic                        rhit,
   input  logic [idx_w(DEPTH)-1:0]     raddr,
   output logic [DATA_W-1:0]           rdata
);

   localparam int STRB_W = strb_w(DATA_W);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: every word is cleared under reset, so this maps to flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int w = 0; w < DEPTH; w++) begin
            mem[w] <= '0;
         end
      end else if (we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (wstrb[i]) begin
               mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= rhit ? mem[raddr] : '0;
      end
   end

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 slave fronting a word-addressed memory with a programmable number of wait states.
// Out-of-range accesses complete with pslverr and never touch storage.
module apb4_mem_slave
   import apb4_mem_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           paddr,
   input  logic                        psel,
   input  logic                        penable,
   input  logic                        pwrite,
   input  logic [DATA_W-1:0]           pwdata,
   input  logic [strb_w(DATA_W)-1:0]   pstrb,
   output logic [DATA_W-1:0]           prdata,
   output logic                        pready,
   output logic                        pslverr
);

   localparam int                IDX_W   = idx_w(DEPTH);
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [WAIT_W-1:0] WAIT_L  = WAIT_W'(WAIT_STATES);

   apb_state_e        state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_nxt;
   logic [IDX_W-1:0]  addr_q;
   logic              write_q;
   logic              oor_q;

   logic paddr_oor;
   logic setup;
   logic abort;
   logic complete;
   logic mem_we;

   assign paddr_oor = ({1'b0, paddr} >= DEPTH_L);
   assign setup     = (state == IDLE) && psel && !penable;
   assign abort     = (state == ACCESS) && !psel;
   assign complete  = (state == ACCESS) && psel && penable && pready;
   assign mem_we    = complete && write_q && !oor_q;
   assign wait_nxt  = wait_cnt + 1'b1;

   // pready/pslverr are registered: they are computed one edge ahead from the next counter value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         oor_q    <= 1'b0;
         pready   <= 1'b1;
         pslverr  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (setup) begin
                  state    <= ACCESS;
                  addr_q   <= paddr[IDX_W-1:0];
                  write_q  <= pwrite;
                  oor_q    <= paddr_oor;
                  wait_cnt <= '0;
                  pready   <= (WAIT_L == '0);
                  pslverr  <= (WAIT_L == '0) && paddr_oor;
               end
            end
            ACCESS: begin
               if (abort || complete) begin
                  state   <= IDLE;
                  pready  <= 1'b1;
                  pslverr <= 1'b0;
               end else if (!pready) begin
                  wait_cnt <= wait_nxt;
                  pready   <= (wait_nxt == WAIT_L);
                  pslverr  <= (wait_nxt == WAIT_L) && oor_q;
               end
            end
            default: begin
               state   <= IDLE;
               pready  <= 1'b1;
               pslverr <= 1'b0;
            end
         endcase
      end
   end

   // Read data is fetched at setup so it is already stable for the whole access phase.
   apb4_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (addr_q),
      .wdata (pwdata),
      .wstrb (pstrb),
      .re    (setup && !pwrite),
      .rhit  (!paddr_oor),
      .raddr (paddr[IDX_W-1:0]),
      .rdata (prdata)
   );

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench for apb4_mem_slave: default, DEPTH=16 and WAIT_STATES=3 instances on a shared bus.
// Each instance has its own psel; expected values are hand-computed constants.
module tb_apb4_mem_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  paddr;
   logic [2:0]  psel_v;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata_v [3];
   logic [2:0]  pready_v;
   logic [2:0]  pslverr_v;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int c0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb4_mem_slave u_def (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0])
   );

   apb4_mem_slave #(.DEPTH(16)) u_d16 (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1])
   );

   apb4_mem_slave #(.WAIT_STATES(3)) u_w3 (
      .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
      .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transfer on instance d; leaves the bus just after the completion edge.
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] strb, input logic flip,
                       input logic exp_err, input int exp_wait, input logic [31:0] exp_rd,
                       input string tag);
      int waits;
      @(negedge clk);
      psel_v    = '0;
      psel_v[d] = 1'b1;
      penable   = 1'b0;
      pwrite    = wr;
      paddr     = addr;
      pwdata    = data;
      pstrb     = strb;
      @(negedge clk);
      penable = 1'b1;
      if (flip) begin
         pwrite = ~wr;
         pwdata = 32'h0000_00FF;
         pstrb  = 4'hF;
      end
      waits = 0;
      while (pready_v[d] !== 1'b1 && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      check({tag, ".wait"}, 32'(waits), 32'(exp_wait));
      check({tag, ".err"}, 32'(pslverr_v[d]), 32'(exp_err));
      check({tag, ".rd"}, prdata_v[d], exp_rd);
      @(posedge clk);
      #1;
   endtask

   // Write setup followed by psel dropping in the access phase.
   task automatic abort_write(input int d, input logic [7:0] addr, input logic [31:0] data,
                              input string tag);
      @(negedge clk);
      psel_v    = '0;
      psel_v[d] = 1'b1;
      penable   = 1'b0;
      pwrite    = 1'b1;
      paddr     = addr;
      pwdata    = data;
      pstrb     = 4'hF;
      @(negedge clk);
      psel_v  = '0;
      penable = 1'b1;
      @(negedge clk);
      check({tag, ".rdy"}, 32'(pready_v[d]), 32'd1);
      check({tag, ".err"}, 32'(pslverr_v[d]), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      psel_v  = '0;
      penable = 1'b0;
      pwrite  = 1'b0;
      paddr   = '0;
      pwdata  = '0;
      pstrb   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.rdy0", 32'(pready_v[0]), 32'd1);
      check("rst.err0", 32'(pslverr_v[0]), 32'd0);
      check("rst.rd0", prdata_v[0], 32'd0);
      rst = 1'b0;

      // Default instance: basic write/read, zero strobes, prdata hold.
      xfer(0, 1'b1, 8'h32, 32'h0000_0061, 4'hF, 1'b0, 1'b0, 0, 32'h0, "w32");
      xfer(0, 1'b0, 8'h32, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0000_0061, "r32");
      xfer(0, 1'b1, 8'h32, 32'h0000_DEAD, 4'h0, 1'b0, 1'b0, 0, 32'h0000_0061, "w32nostrb");
      xfer(0, 1'b0, 8'h32, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0000_0061, "r32again");

      // Ignored traffic must not disturb word 0.
      xfer(0, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 0, 32'h0000_0061, "w00");
      @(negedge clk);
      psel_v  = '0;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h00;
      pwdata  = 32'h0000_00FF;
      pstrb   = 4'hF;
      @(negedge clk);
      psel_v[0] = 1'b1;
      penable   = 1'b1;
      @(negedge clk);
      check("nosetup.rdy", 32'(pready_v[0]), 32'd1);
      check("nosetup.err", 32'(pslverr_v[0]), 32'd0);
      xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b1, 1'b0, 0, 32'hFFFF_FFFF, "rflip");
      xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, "r00");

      // Partial strobes and the highest address.
      xfer(0, 1'b1, 8'h10, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, "w10full");
      xfer(0, 1'b1, 8'h10, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 0, 32'hFFFF_FFFF, "w10part");
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h11BB_33DD, "r10");
      xfer(0, 1'b1, 8'hFF, 32'hA5A5_A5A5, 4'hF, 1'b0, 1'b0, 0, 32'h11BB_33DD, "wFF");
      xfer(0, 1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'hA5A5_A5A5, "rFF");

      // DEPTH=16 instance: range errors and aliasing addresses.
      xfer(1, 1'b1, 8'h03, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 0, 32'h0, "d16.w03");
      xfer(1, 1'b1, 8'h20, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 0, 32'h0, "d16.w20");
      xfer(1, 1'b1, 8'h13, 32'h0BAD_BEEF, 4'hF, 1'b0, 1'b1, 0, 32'h0, "d16.w13");
      xfer(1, 1'b1, 8'h0F, 32'h5A5A_0F0F, 4'hF, 1'b0, 1'b0, 0, 32'h0, "d16.w0F");
      xfer(1, 1'b0, 8'h03, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'hCAFE_F00D, "d16.r03");
      xfer(1, 1'b0, 8'h20, 32'h0, 4'h0, 1'b0, 1'b1, 0, 32'h0, "d16.r20");
      xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0, "d16.r00");
      xfer(1, 1'b0, 8'h0F, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h5A5A_0F0F, "d16.r0F");

      // WAIT_STATES=3 instance: back-to-back pairs take 2*(2+3) cycles.
      c0 = cyc;
      xfer(2, 1'b1, 8'hFE, 32'h0000_0031, 4'hF, 1'b0, 1'b0, 3, 32'h0, "w3.wFE");
      xfer(2, 1'b1, 8'hFF, 32'h0000_0032, 4'hF, 1'b0, 1'b0, 3, 32'h0, "w3.wFF");
      check("w3.wcycles", 32'(cyc - c0), 32'd10);
      c0 = cyc;
      xfer(2, 1'b0, 8'hFE, 32'h0, 4'h0, 1'b0, 1'b0, 3, 32'h0000_0031, "w3.rFE");
      xfer(2, 1'b0, 8'hFF, 32'h0, 4'h0, 1'b0, 1'b0, 3, 32'h0000_0032, "w3.rFF");
      check("w3.rcycles", 32'(cyc - c0), 32'd10);

      // Reset during an access phase, then an aborted write.
      xfer(0, 1'b1, 8'h05, 32'h0000_0077, 4'hF, 1'b0, 1'b0, 0, 32'hA5A5_A5A5, "w05");
      xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0000_0077, "r05");
      @(negedge clk);
      psel_v  = 3'b001;
      penable = 1'b0;
      pwrite  = 1'b1;
      paddr   = 8'h05;
      pwdata  = 32'h0000_0099;
      pstrb   = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      rst     = 1'b1;
      @(negedge clk);
      rst     = 1'b0;
      psel_v  = '0;
      penable = 1'b0;
      check("midrst.rdy", 32'(pready_v[0]), 32'd1);
      check("midrst.err", 32'(pslverr_v[0]), 32'd0);
      check("midrst.rd", prdata_v[0], 32'd0);
      xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0, "r05rst");
      xfer(0, 1'b1, 8'h05, 32'h0000_0055, 4'hF, 1'b0, 1'b0, 0, 32'h0, "w05b");
      abort_write(0, 8'h05, 32'h0000_00AA, "abort");
      xfer(0, 1'b0, 8'h05, 32'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0000_0055, "r05abort");

      @(negedge clk);
      psel_v  = '0;
      penable = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
